// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared types, widths and sample saturation for the I2S DAC transmitter
// Purpose: shared definitions for i2s_dac_tx and its sub-modules.
//   IN_W / OUT_W       : input sample width and serialized word width
//   tx_state_e         : serializer states
//   SAMPLE_MAX / MIN   : OUT_W signed range limits
//   saturate()         : clamp an IN_W signed sample into OUT_W
package i2s_tx_pkg;

   localparam int IN_W  = 21;
   localparam int OUT_W = 16;

   typedef enum logic [1:0] {IDLE, ARM, SHIFT, PAD} tx_state_e;

   localparam int SAMPLE_MAX = (2 ** (OUT_W - 1)) - 1;
   localparam int SAMPLE_MIN = -(2 ** (OUT_W - 1));

   function automatic logic [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] x);
      if ($signed(x) > $signed(IN_W'(SAMPLE_MAX)))
         return OUT_W'(SAMPLE_MAX);
      else if ($signed(x) < $signed(IN_W'(SAMPLE_MIN)))
         return OUT_W'(SAMPLE_MIN);
      else
         return x[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// rtl/i2s_edge_sync.sv - 2-FF synchronizer with single-cycle rise/fall strobes
// Purpose: bring an asynchronous codec clock pin into the clk domain and
//          flag its edges.
// Ports:
//   clk      in   system clock
//   i_rst_n  in   synchronous active-low clear (reset or disable)
//   i_pin    in   asynchronous input pin
//   o_rise   out  one-cycle strobe on a synchronized 0->1 transition
//   o_fall   out  one-cycle strobe on a synchronized 1->0 transition
module i2s_edge_sync (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_pin,
   output logic o_rise,
   output logic o_fall
);

   logic       sync1;
   logic       sync2;
   logic       prev;
   logic [1:0] fill;

   // After a clear the pipeline holds zeros rather than the pin level; the
   // strobes stay masked until all three stages carry real samples so that a
   // pin sitting high is not mistaken for a fresh edge.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         fill  <= 2'd0;
      end else begin
         sync1 <= i_pin;
         sync2 <= sync1;
         prev  <= sync2;
         if (fill != 2'd3)
            fill <= fill + 2'd1;
      end
   end

   assign o_rise = (fill == 2'd3) &&  sync2 && !prev;
   assign o_fall = (fill == 2'd3) && !sync2 &&  prev;

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC transmitter, mono sample duplicated into left and right slots
// Purpose: accept IN_W signed samples over valid/ready, convert to OUT_W and
//          serialize MSB-first in I2S format following codec BCLK/LRCLK.
// Optional feature: define I2S_TX_SAT_EN for saturating conversion; otherwise
//          the low OUT_W bits are taken (wrap).
// Ports:
//   clk         in   system clock, at least 4x BCLK
//   i_rst_n     in   synchronous active-low reset
//   i_en        in   enable; low flushes the block to its reset state
//   i_bclk      in   codec bit clock (asynchronous)
//   i_lrclk     in   codec LR clock (asynchronous), low = left slot
//   i_valid     in   i_audio valid
//   i_audio     in   IN_W signed sample
//   o_ready     out  holding register empty
//   o_dacdat    out  serial DAC data
//   o_underrun  out  one-cycle pulse: left frame started without a new sample
module i2s_dac_tx
   import i2s_tx_pkg::*;
(
   input  logic            clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic            i_bclk,
   input  logic            i_lrclk,
   input  logic            i_valid,
   input  logic [IN_W-1:0] i_audio,
   output logic            o_ready,
   output logic            o_dacdat,
   output logic            o_underrun
);

   logic             run_n;
   logic             bclk_fall;
   logic             unused_bclk_rise;
   logic             lrc_rise;
   logic             lrc_fall;
   logic             lrc_edge;
   logic             accept;
   logic [OUT_W-1:0] conv;
   logic [OUT_W-1:0] hold;
   logic             hold_full;
   logic [OUT_W-1:0] frame;

   tx_state_e        state, state_n;
   logic [OUT_W-1:0] shreg, shreg_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic             dat_n;

   // Reset and disable share one clear path.
   assign run_n = i_rst_n & i_en;

   i2s_edge_sync u_bclk_sync (
      .clk     (clk),
      .i_rst_n (run_n),
      .i_pin   (i_bclk),
      .o_rise  (unused_bclk_rise),
      .o_fall  (bclk_fall)
   );

   i2s_edge_sync u_lrc_sync (
      .clk     (clk),
      .i_rst_n (run_n),
      .i_pin   (i_lrclk),
      .o_rise  (lrc_rise),
      .o_fall  (lrc_fall)
   );

   assign lrc_edge = lrc_rise | lrc_fall;

`ifdef I2S_TX_SAT_EN
   assign conv = saturate(i_audio);
`else
   logic unused_msbs;
   assign conv        = i_audio[OUT_W-1:0];
   assign unused_msbs = ^i_audio[IN_W-1:OUT_W];
`endif

   assign o_ready = !hold_full;
   assign accept  = i_valid && o_ready;

   // Frame load looks at the old hold_full, so a sample accepted in the same
   // cycle as lrc_fall waits in hold for the next left frame.
   always_ff @(posedge clk) begin
      if (!run_n) begin
         hold       <= '0;
         hold_full  <= 1'b0;
         frame      <= '0;
         o_underrun <= 1'b0;
      end else begin
         o_underrun <= lrc_fall && !hold_full;
         if (lrc_fall && hold_full) begin
            frame     <= hold;
            hold_full <= 1'b0;
         end else if (accept) begin
            hold      <= conv;
            hold_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!run_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         o_dacdat <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         o_dacdat <= dat_n;
      end
   end

   // An LRC edge always wins over a coincident BCLK fall: the word starts on
   // the following fall, which produces the I2S one-bit delay and truncates
   // (never shifts) an over-long word when a slot is short.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      dat_n     = o_dacdat;
      if (state == IDLE) begin
         dat_n = 1'b0;
         if (lrc_edge)
            state_n = ARM;
      end else if (lrc_edge) begin
         state_n = ARM;
         dat_n   = 1'b0;
      end else begin
         case (state)
            ARM: begin
               if (bclk_fall) begin
                  shreg_n   = frame;
                  dat_n     = frame[OUT_W-1];
                  bit_cnt_n = 4'(OUT_W - 1);
                  state_n   = SHIFT;
               end
            end
            SHIFT: begin
               if (bclk_fall) begin
                  if (bit_cnt == 4'd0) begin
                     dat_n   = 1'b0;
                     state_n = PAD;
                  end else begin
                     shreg_n   = {shreg[OUT_W-2:0], 1'b0};
                     dat_n     = shreg[OUT_W-2];
                     bit_cnt_n = bit_cnt - 4'd1;
                  end
               end
            end
            PAD: begin
               dat_n = 1'b0;
            end
            default: begin
               state_n = IDLE;
               dat_n   = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - self-checking bench for i2s_dac_tx
module tb_i2s_dac_tx;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_en = 1'b1;
   logic        i_bclk = 1'b1;
   logic        i_lrclk = 1'b0;
   logic        i_valid = 1'b0;
   logic [20:0] i_audio = '0;
   logic        o_ready;
   logic        o_dacdat;
   logic        o_underrun;

   int   checks = 0;
   int   errors = 0;
   int   ur_total = 0;
   int   ur0;
   logic cap [0:63];
   logic rst_dat;
   logic rst_rdy;

   i2s_dac_tx dut (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_bclk     (i_bclk),
      .i_lrclk    (i_lrclk),
      .i_valid    (i_valid),
      .i_audio    (i_audio),
      .o_ready    (o_ready),
      .o_dacdat   (o_dacdat),
      .o_underrun (o_underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (o_underrun === 1'b1) ur_total++;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] cap_word();
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[15-k] = cap[1+k];
      return w;
   endfunction

   function automatic int cap_ones(input int lo, input int hi);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (cap[k] !== 1'b0) c++;
      return c;
   endfunction

   // One LRC slot of n BCLK periods (8 clk each); LRC changes with the first
   // BCLK fall. o_dacdat is captured at every BCLK rise. rst_at pulses reset
   // three clk after fall number rst_at.
   task automatic slot(input int n, input logic lr, input int rst_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         i_bclk = 1'b0;
         if (i == 0) i_lrclk = lr;
         repeat (3) @(negedge clk);
         if (i == rst_at) begin
            i_rst_n = 1'b0;
            @(negedge clk);
            rst_dat = o_dacdat;
            rst_rdy = o_ready;
            i_rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
         i_bclk = 1'b1;
         cap[i] = o_dacdat;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic send(input logic [20:0] s);
      int t;
      @(negedge clk);
      i_audio = s;
      i_valid = 1'b1;
      t = 0;
      while (o_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL send_timeout o_ready=%b required 1", o_ready);
      end
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
      checks++;
      if (o_dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b exp 0", o_dacdat); end
      checks++;
      if (o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", o_underrun); end
      i_rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      send(21'h000ABC);
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low got %b exp 0", o_ready); end
      ur0 = ur_total;
      slot(32, 1'b1, -1);
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'h0ABC) begin errors++; $display("FAIL basic_left_word got %h exp 0abc", cap_word()); end
      checks++;
      if (cap_ones(17, 31) != 0) begin errors++; $display("FAIL basic_left_pad got %0d ones exp 0", cap_ones(17, 31)); end
      slot(32, 1'b1, -1);
      checks++;
      if (cap_word() !== 16'h0ABC) begin errors++; $display("FAIL basic_right_word got %h exp 0abc", cap_word()); end
      checks++;
      if (cap_ones(17, 31) != 0) begin errors++; $display("FAIL basic_right_pad got %0d ones exp 0", cap_ones(17, 31)); end
      checks++;
      if (ur_total - ur0 != 0) begin errors++; $display("FAIL basic_underrun got %0d exp 0", ur_total - ur0); end
   endtask

   task automatic test_saturation();
      logic [15:0] exp_w;
`ifdef I2S_TX_SAT_EN
      exp_w = 16'h7FFF;
`else
      exp_w = 16'hFFFF;
`endif
      send(21'h07FFFF);
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== exp_w) begin errors++; $display("FAIL sat_left_word got %h exp %h", cap_word(), exp_w); end
      slot(32, 1'b1, -1);
      checks++;
      if (cap_word() !== exp_w) begin errors++; $display("FAIL sat_right_word got %h exp %h", cap_word(), exp_w); end
   endtask

   task automatic test_underrun();
      send(21'h001234);
      ur0 = ur_total;
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'h1234) begin errors++; $display("FAIL ur_frame0 got %h exp 1234", cap_word()); end
      slot(32, 1'b1, -1);
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'h1234) begin errors++; $display("FAIL ur_frame1 got %h exp 1234", cap_word()); end
      checks++;
      if (ur_total - ur0 != 1) begin errors++; $display("FAIL ur_count1 got %0d exp 1", ur_total - ur0); end
      slot(32, 1'b1, -1);
      checks++;
      if (cap_word() !== 16'h1234) begin errors++; $display("FAIL ur_frame1_right got %h exp 1234", cap_word()); end
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'h1234) begin errors++; $display("FAIL ur_frame2 got %h exp 1234", cap_word()); end
      checks++;
      if (ur_total - ur0 != 2) begin errors++; $display("FAIL ur_count2 got %0d exp 2", ur_total - ur0); end
      slot(32, 1'b1, -1);
   endtask

   task automatic test_back_to_back();
      int t;
      @(negedge clk);
      i_audio = 21'h005A5A;
      i_valid = 1'b1;
      t = 0;
      while (o_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_first got %b exp 0", o_ready); end
      i_audio = 21'h1FC3C3;
      repeat (4) @(negedge clk);
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_held_off got %b exp 0", o_ready); end
      ur0 = ur_total;
      slot(32, 1'b0, -1);
      i_valid = 1'b0;
      checks++;
      if (cap_word() !== 16'h5A5A) begin errors++; $display("FAIL b2b_first_word got %h exp 5a5a", cap_word()); end
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken got %b exp 0", o_ready); end
      slot(32, 1'b1, -1);
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'hC3C3) begin errors++; $display("FAIL b2b_second_word got %h exp c3c3", cap_word()); end
      checks++;
      if (ur_total - ur0 != 0) begin errors++; $display("FAIL b2b_underrun got %0d exp 0", ur_total - ur0); end
      slot(32, 1'b1, -1);
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] hi;
      send(21'h003C5A);
      slot(32, 1'b0, -1);
      send(21'h0055AA);
      slot(32, 1'b1, 9);
      for (int k = 0; k < 8; k++) hi[7-k] = cap[1+k];
      checks++;
      if (hi !== 8'h3C) begin errors++; $display("FAIL rst_bits_before got %h exp 3c", hi); end
      checks++;
      if (rst_dat !== 1'b0) begin errors++; $display("FAIL rst_dacdat got %b exp 0", rst_dat); end
      checks++;
      if (rst_rdy !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", rst_rdy); end
      checks++;
      if (cap_ones(10, 31) != 0) begin errors++; $display("FAIL rst_silent got %0d ones exp 0", cap_ones(10, 31)); end
      send(21'h00F00F);
      slot(32, 1'b0, -1);
      checks++;
      if (cap_word() !== 16'hF00F) begin errors++; $display("FAIL rst_resume_word got %h exp f00f", cap_word()); end
   endtask

   task automatic test_truncation();
      logic [8:0] part;
      send(21'h00C3A5);
      slot(10, 1'b1, -1);
      slot(10, 1'b0, -1);
      for (int k = 0; k < 9; k++) part[8-k] = cap[1+k];
      checks++;
      if (part !== 9'h187) begin errors++; $display("FAIL trunc_bits got %h exp 187", part); end
      slot(32, 1'b1, -1);
      checks++;
      if (cap_word() !== 16'hC3A5) begin errors++; $display("FAIL trunc_next_aligned got %h exp c3a5", cap_word()); end
      checks++;
      if (cap_ones(17, 31) != 0) begin errors++; $display("FAIL trunc_next_pad got %0d ones exp 0", cap_ones(17, 31)); end
   endtask

   initial begin
      for (int k = 0; k < 64; k++) cap[k] = 1'b0;
      rst_dat = 1'bx;
      rst_rdy = 1'bx;
      test_reset();
      test_basic();
      test_saturation();
      test_underrun();
      test_back_to_back();
      test_reset_mid_word();
      test_truncation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
